// File: rtl/common_pkg.sv
// Shared defaults and types for the link-side VC scheduler and its arbiter.
// The lock-state enum is only consumed when VC_SCHED_PACKET_LOCK_EN is defined.
package common_pkg;

    localparam int DEFAULT_VC_W          = 4;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
    localparam int DEFAULT_FLIT_W        = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // A one-entry pointer still needs a 1-bit register.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or above ptr wins,
// wrapping to index 0. Returns a one-hot grant and the winner's index.
module rr_arbiter
    import common_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic found;

    // Two ascending passes: [ptr, N) first, then the wrapped [0, ptr).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j < int'(ptr))) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/vc_credit_scheduler.sv
// Credit-based round-robin VC scheduler driving one registered link output.
// Define VC_SCHED_PACKET_LOCK_EN for wormhole locking (adds i_vc_last / o_last).
module vc_credit_scheduler
    import common_pkg::*;
#(
    parameter int VC_W   = DEFAULT_VC_W,
    parameter int DEPTH  = DEFAULT_VC_FIFO_DEPTH,
    parameter int DATA_W = DEFAULT_FLIT_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [VC_W-1:0]          i_vc_valid,
    input  logic [VC_W*DATA_W-1:0]   i_vc_data,
    output logic [VC_W-1:0]          o_vc_ready,
    input  logic [VC_W-1:0]          i_vc_credit_gnt,
`ifdef VC_SCHED_PACKET_LOCK_EN
    input  logic [VC_W-1:0]          i_vc_last,
    output logic                     o_last,
`endif
    output logic                     o_valid,
    output logic [VC_W-1:0]          o_vc_id,
    output logic [DATA_W-1:0]        o_data,
    output logic [VC_W*$clog2(DEPTH)-1:0] o_credits
);

    localparam int CNT_W = $clog2(DEPTH);
    localparam int PTR_W = ptr_width(VC_W);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH - 1);

    // Handshake: o_vc_ready[k] is the pop for queue k; it depends only on
    // i_vc_valid and registered state, and the queue pops on the same edge.

    logic [CNT_W-1:0]  credits [VC_W];
    logic [PTR_W-1:0]  ptr;
    logic [VC_W-1:0]   elig;
    logic [VC_W-1:0]   req;
    logic [VC_W-1:0]   grant;
    logic [PTR_W-1:0]  grant_idx;
    logic [DATA_W-1:0] win_data;
    logic              ptr_adv;

    always_comb begin
        elig = '0;
        for (int i = 0; i < VC_W; i++) begin
            elig[i] = i_vc_valid[i] && (credits[i] != '0);
        end
    end

`ifdef VC_SCHED_PACKET_LOCK_EN
    lock_state_e     lock_state;
    logic [VC_W-1:0] lock_mask;
    logic            win_last;

    // While locked only the owning VC may compete; no bypass on stall.
    assign req = (lock_state == LOCKED) ? (elig & lock_mask) : elig;

    always_comb begin
        win_last = 1'b0;
        for (int j = 0; j < VC_W; j++) begin
            if (grant[j]) win_last = i_vc_last[j];
        end
    end

    assign ptr_adv = (|grant) && win_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_state <= IDLE;
            lock_mask  <= '0;
        end else if (|grant) begin
            if (win_last) begin
                lock_state <= IDLE;
                lock_mask  <= '0;
            end else begin
                lock_state <= LOCKED;
                lock_mask  <= grant;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_last <= 1'b0;
        end else if (|grant) begin
            o_last <= win_last;
        end else begin
            o_last <= 1'b0;
        end
    end
`else
    assign req     = elig;
    assign ptr_adv = |grant;
`endif

    rr_arbiter #(
        .N     (VC_W),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign o_vc_ready = grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (ptr_adv) begin
            if (int'(grant_idx) == VC_W - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + PTR_W'(1);
            end
        end
    end

    // Spend and return in the same cycle cancel out; a return at full
    // credit is a receiver bug, so the count saturates instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < VC_W; i++) credits[i] <= CREDIT_MAX;
        end else begin
            for (int i = 0; i < VC_W; i++) begin
                case ({grant[i], i_vc_credit_gnt[i]})
                    2'b10:   credits[i] <= credits[i] - CNT_W'(1);
                    2'b01:   if (credits[i] != CREDIT_MAX) credits[i] <= credits[i] + CNT_W'(1);
                    default: credits[i] <= credits[i];
                endcase
            end
        end
    end

    always_comb begin
        o_credits = '0;
        for (int i = 0; i < VC_W; i++) begin
            o_credits[i*CNT_W +: CNT_W] = credits[i];
        end
    end

    always_comb begin
        win_data = '0;
        for (int j = 0; j < VC_W; j++) begin
            if (grant[j]) win_data = i_vc_data[j*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_vc_id <= '0;
            o_data  <= '0;
        end else begin
            o_valid <= |grant;
            o_vc_id <= grant;
            if (|grant) o_data <= win_data;
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_vc_ready));

    a_ctrl_known: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !$isunknown({o_valid, o_vc_id, o_vc_ready}));

    for (genvar g = 0; g < VC_W; g++) begin : g_credit_chk
        a_credit_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            credits[g] <= CREDIT_MAX);
        a_no_overflow_return: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            !(i_vc_credit_gnt[g] && !grant[g] && (credits[g] == CREDIT_MAX)));
    end
`endif

endmodule

// File: tb/tb_vc_credit_scheduler.sv
// Directed table-driven bench for vc_credit_scheduler (VC_W=4, DEPTH=4, DATA_W=8),
// plus a hand-written async-reset-mid-stream sequence.
module tb_vc_credit_scheduler;

    localparam int VC_W   = 4;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int NVEC   = 16;

    logic                   i_clk;
    logic                   i_rst_n;
    logic [VC_W-1:0]        i_vc_valid;
    logic [VC_W*DATA_W-1:0] i_vc_data;
    logic [VC_W-1:0]        o_vc_ready;
    logic [VC_W-1:0]        i_vc_credit_gnt;
    logic                   o_valid;
    logic [VC_W-1:0]        o_vc_id;
    logic [DATA_W-1:0]      o_data;
    logic [VC_W*CNT_W-1:0]  o_credits;

    vc_credit_scheduler #(
        .VC_W   (VC_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_vc_valid      (i_vc_valid),
        .i_vc_data       (i_vc_data),
        .o_vc_ready      (o_vc_ready),
        .i_vc_credit_gnt (i_vc_credit_gnt),
        .o_valid         (o_valid),
        .o_vc_id         (o_vc_id),
        .o_data          (o_data),
        .o_credits       (o_credits)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [VC_W-1:0]       valid;
        logic [VC_W-1:0]       gnt;
        logic [VC_W-1:0]       exp_ready;
        logic [VC_W*CNT_W-1:0] exp_credits;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_cmp;
    int   n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pick_data(input logic [VC_W*DATA_W-1:0] d,
                                                    input logic [VC_W-1:0] oh);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int j = 0; j < VC_W; j++) if (oh[j]) r = d[j*DATA_W +: DATA_W];
        return r;
    endfunction

    task automatic drive(input logic [VC_W-1:0] v, input logic [VC_W-1:0] g);
        i_vc_valid      = v;
        i_vc_credit_gnt = g;
        i_vc_data       = $urandom;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_d;
        n_cmp = 0;
        n_err = 0;

        // Credits packed as {c3,c2,c1,c0}; ptr noted as after-the-edge value.
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, {2'd3, 2'd3, 2'd3, 2'd2}}; // ptr 1
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, {2'd3, 2'd3, 2'd2, 2'd2}}; // ptr 2
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, {2'd3, 2'd2, 2'd2, 2'd2}}; // ptr 3
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, {2'd2, 2'd2, 2'd2, 2'd2}}; // ptr 0
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, {2'd2, 2'd2, 2'd2, 2'd1}}; // ptr 1, wrap
        vecs[5]  = '{4'b0001, 4'b0000, 4'b0001, {2'd2, 2'd2, 2'd2, 2'd0}}; // VC0 third grant
        vecs[6]  = '{4'b0001, 4'b0000, 4'b0000, {2'd2, 2'd2, 2'd2, 2'd0}}; // exhausted
        vecs[7]  = '{4'b0001, 4'b0001, 4'b0000, {2'd2, 2'd2, 2'd2, 2'd1}}; // return not yet usable
        vecs[8]  = '{4'b0001, 4'b0000, 4'b0001, {2'd2, 2'd2, 2'd2, 2'd0}}; // one more grant
        vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, {2'd2, 2'd2, 2'd2, 2'd0}}; // idle
        vecs[10] = '{4'b0010, 4'b0000, 4'b0010, {2'd2, 2'd2, 2'd1, 2'd0}}; // VC1 down to 1
        vecs[11] = '{4'b0010, 4'b0010, 4'b0010, {2'd2, 2'd2, 2'd1, 2'd0}}; // spend + return
        vecs[12] = '{4'b0000, 4'b1111, 4'b0000, {2'd3, 2'd3, 2'd2, 2'd1}}; // returns only
        vecs[13] = '{4'b1010, 4'b0000, 4'b1000, {2'd2, 2'd3, 2'd2, 2'd1}}; // ptr 2 -> VC3
        vecs[14] = '{4'b1010, 4'b0000, 4'b0010, {2'd2, 2'd3, 2'd1, 2'd1}}; // ptr 0 -> VC1
        vecs[15] = '{4'b1111, 4'b0000, 4'b0100, {2'd2, 2'd2, 2'd1, 2'd1}}; // ptr 2 -> VC2, ptr 3

        i_rst_n         = 1'b0;
        i_vc_valid      = '0;
        i_vc_credit_gnt = '0;
        i_vc_data       = '0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;

        check("reset_credits", 64'(o_credits), 64'({2'd3, 2'd3, 2'd3, 2'd3}));
        check("reset_valid",   64'(o_valid),   64'(0));
        check("reset_vc_id",   64'(o_vc_id),   64'(0));
        check("reset_data",    64'(o_data),    64'(0));
        check("reset_ready_idle", 64'(o_vc_ready), 64'(0));

        // Driver + compare loop: inputs at negedge, ready just after, registers next negedge
        for (int r = 0; r < NVEC; r++) begin
            drive(vecs[r].valid, vecs[r].gnt);
            #1;
            check($sformatf("ready[%0d]", r), 64'(o_vc_ready), 64'(vecs[r].exp_ready));
            exp_d = pick_data(i_vc_data, vecs[r].exp_ready);
            @(posedge i_clk);
            @(negedge i_clk);
            check($sformatf("valid[%0d]", r),   64'(o_valid),   64'(|vecs[r].exp_ready));
            check($sformatf("vc_id[%0d]", r),   64'(o_vc_id),   64'(vecs[r].exp_ready));
            check($sformatf("credits[%0d]", r), 64'(o_credits), 64'(vecs[r].exp_credits));
            if (|vecs[r].exp_ready) check($sformatf("data[%0d]", r), 64'(o_data), 64'(exp_d));
        end

        // Async reset mid-stream: ptr is 3 here, so VC1 wins and ptr moves to 2.
        drive(4'b0010, 4'b0000);
        #1;
        check("pre_rst_ready", 64'(o_vc_ready), 64'(4'b0010));
        @(posedge i_clk);
        #2;
        check("pre_rst_valid", 64'(o_valid), 64'(1));
        i_rst_n = 1'b0;
        #1;
        check("async_rst_valid",   64'(o_valid),   64'(0));
        check("async_rst_vc_id",   64'(o_vc_id),   64'(0));
        check("async_rst_data",    64'(o_data),    64'(0));
        check("async_rst_credits", 64'(o_credits), 64'({2'd3, 2'd3, 2'd3, 2'd3}));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(4'b1111, 4'b0000);
        #1;
        check("post_rst_ptr0", 64'(o_vc_ready), 64'(4'b0001));
        exp_d = pick_data(i_vc_data, 4'b0001);
        @(posedge i_clk);
        @(negedge i_clk);
        check("post_rst_vc_id",   64'(o_vc_id),   64'(4'b0001));
        check("post_rst_data",    64'(o_data),    64'(exp_d));
        check("post_rst_credits", 64'(o_credits), 64'({2'd3, 2'd3, 2'd3, 2'd2}));

        drive(4'b0000, 4'b0000);
        @(negedge i_clk);
        check("drain_valid", 64'(o_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vc_credit_scheduler.md
Name: vc_credit_scheduler

Overview:
- Transmit-side scheduler for one output link shared by VC_W virtual-channel queues.
- Keeps its own per-VC credit counters and chooses one eligible VC per cycle (has a flit and holds at least one credit) in round-robin order.
- Spends the credit, pops the winning queue, and drives the flit into a registered output stage toward the downstream router.
- Sits between the per-VC input FIFOs and the link; the downstream receiver returns credits.

Parameters:
- VC_W, DEFAULT_VC_W: number of virtual channels (≥1).
- DEPTH, DEFAULT_VC_FIFO_DEPTH: downstream per-VC FIFO depth; usable credits = DEPTH-1.
- DATA_W, DEFAULT_FLIT_W: flit width in bits.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_vc_valid  in  VC_W  per-VC queue has a flit
- i_vc_data  in  VC_W x DATA_W  per-VC head flit
- o_vc_ready  out  VC_W  one-hot0 pop/grant to the winning queue (combinational)
- i_vc_credit_gnt  in  VC_W  credit return from receiver, one per VC per cycle
- o_valid  out  1  registered flit valid to link
- o_vc_id  out  VC_W  registered one-hot VC tag of o_data
- o_data  out  DATA_W  registered flit
- o_credits  out  VC_W x CNT_W  current credit counts, CNT_W = $clog2(DEPTH)

Behaviour:
- Reset (async assert, sync-released by the environment):
  - credits[i] = DEPTH-1
  - rr pointer = 0
  - o_valid = 0, o_vc_id = 0, o_data = 0
  - lock state = IDLE (when the optional feature is enabled)
- Eligibility: elig[i] = i_vc_valid[i] && credits[i] != 0.
- Arbitration (combinational):
  - Search elig starting at index ptr, ascending with wrap mod VC_W; first hit wins.
  - o_vc_ready = one-hot of the winner, 0 if none.
  - The queue pops on that same edge; there is no ready/valid dependency loop, because ready never depends on anything except valid and the registered state.
- Pointer: on a grant to VC k, ptr <= (k+1) mod VC_W; otherwise unchanged.
- Credits, per VC per edge:
  - grant & !gnt: -1
  - gnt & !grant: +1
  - both or neither: unchanged
  - A return while at DEPTH-1 saturates (holds) and raises the simulation assertion.
  - Underflow cannot occur by construction.
- Output stage, latency 1 cycle from grant to o_valid:
  - o_valid <= |grant
  - o_vc_id <= grant
  - o_data <= i_vc_data[winner]
  - When there is no grant, o_valid <= 0 and o_vc_id <= 0; o_data holds its value (don't-care).
- No link backpressure: credits guarantee downstream space.
- Boundary conditions:
  - All credits 0: no grants, o_valid = 0.
  - VC_W = 1: ptr is constant 0.
  - A credit returned in cycle t makes the VC eligible in cycle t+1, not t.
  - Reset mid-transfer discards the output register contents and restores full credits; the receiver must be reset together with this block.
- Simulation assertions:
  - o_vc_ready is onehot0.
  - No X on control signals out of reset.
  - credits never exceed DEPTH-1.

Optional Feature:
- Macro VC_SCHED_PACKET_LOCK_EN enables wormhole locking.
- Added ports: i_vc_last (in, VC_W) and o_last (out, 1, registered alongside o_data).
- State machine: IDLE -> LOCKED(k) on a grant to VC k with !i_vc_last[k]; LOCKED(k) -> IDLE on a grant to k with i_vc_last[k].
- In LOCKED(k) only VC k is eligible; if k lacks credits or valid, nothing is granted (stall, no bypass).
- ptr advances only on the IDLE transition (i.e. after the last flit).
- Without the macro, arbitration is per flit, the ports do not exist, and there is no lock state.

Decomposition:
- common_pkg holds DEFAULT_FLIT_W (added) and a lock_state_e enum {IDLE, LOCKED}.
- CNT_W is a localparam.
- One natural sub-module: rr_arbiter (VC_W request vector, pointer in, one-hot grant out, purely combinational), reusable by other routers.
- Credit counters stay inline.

Test Plan:
- Reset credits: VC_W=2, DEPTH=4 → o_credits = {3,3}, o_valid = 0 from the first cycle after reset release.
- Fairness: all VCs valid with full credits, VC_W=4 → grants 0,1,2,3,0,…; o_vc_id follows one cycle later.
- Credit exhaustion: DEPTH=4, VC0 only valid, no gnt → three grants, then o_vc_ready = 0. A single i_vc_credit_gnt[0] gives exactly one more grant the following cycle.
- Simultaneous spend and return: with VC1 at 1 credit, grant VC1 while i_vc_credit_gnt[1] = 1 → credits stay 1.
- Async reset mid-stream: assert i_rst_n low between clock edges → o_valid drops immediately, credits return to DEPTH-1, ptr = 0.
- Lock (macro on): VC0 sends a 3-flit packet while VC1 is valid → VC1 is granted only after VC0's last flit. VC0 at 0 credits mid-packet → stall with no VC1 grant.
